down_counter: RTL and testbench
===============================

# down_counter

Loadable down-counter with a valid/ready load handshake and a terminal-count pulse. It is the counterpart of the free-running up counter in the same reconfigurable region: that counter counts events up from zero, and this block counts a loaded value down to zero. It is a self-contained leaf with no external memory, and its outputs are all registered.

## Interface
- WIDTH, 8, counter and load-value width in bits (≥2)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset; sampled on posedge clk
- enable  input  1  count permission; in COUNT, decrement only when high
- load_valid  input  1  load request; held by the source until accepted
- load_value  input  WIDTH  start value; must be stable while load_valid is high
- load_ready  output  1  block can accept a load (IDLE or DONE)
- out  output  WIDTH  current count value
- busy  output  1  high in COUNT
- done  output  1  high in DONE
- tc  output  1  terminal-count pulse; exactly one cycle wide

## Operation
- States:
  - IDLE: reset state; out=0, load_ready=1.
  - COUNT: counting; busy=1, load_ready=0.
  - DONE: count expired; done=1, load_ready=1, out=0.
- Load acceptance: a load is accepted on an edge where load_valid && load_ready.
  - The accepted load_value is stored in out and in the internal reload register.
  - Next state is COUNT, or DONE if load_value==0.
- COUNT, enable=1: out <= out-1 on each edge.
- COUNT, enable=0: out holds; no other state change.
- Expiry: when out==1 and enable=1 in COUNT:
  - out <= 0
  - tc <= 1
  - next state is DONE (see Configuration for auto-reload).
- Zero load: a load with load_value==0 goes straight to DONE. tc pulses the following cycle and out stays 0.
- Loads are ignored in COUNT because load_ready=0; no abort path exists other than reset.
- DONE persists until the next accepted load. enable has no effect in IDLE or DONE.
- Arithmetic is unsigned modulo 2^WIDTH. Underflow past 0 never occurs, because the transition at out==1 always leaves COUNT or reloads.
- Maximum load: load_value = 2^WIDTH−1 is legal and takes 2^WIDTH−1 enabled cycles to expire.
- Reset has priority over every other input in every state.

## Timing
- Reset values: out=0, tc=0, busy=0, done=0, load_ready=1, reload register=0, state=IDLE.
- Mid-operation reset: reset asserted in any state takes effect at that edge, and outputs take their reset values in the next cycle. A load presented in the same cycle is dropped.
- Load latency: the load is accepted at edge N. At N+1, out=load_value, busy=1 and load_ready=0.
- Count span: a load of V with enable held high gives out=V, V−1, …, 1, 0 on successive cycles. out reaches 0 V cycles after the load edge.
- tc is high exactly in the first cycle out shows 0, or in the first cycle after a zero load. It is low in all other cycles.
- done rises in the same cycle as tc.
- Back-to-back loads: a load presented in the first DONE cycle is accepted, so tc=1 and the acceptance edge coincide. tc still drops the next cycle.

## Configuration
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - At expiry, out <= reload register (not 0) and tc <= 1.
  - State remains COUNT, and DONE is never entered from COUNT.
  - A stored reload value of 0 (zero load) still goes to DONE.
  - tc pulses once every V enabled cycles. out never shows 0 while counting, since the sequence is V…1, V…1.
- Undefined: one-shot behaviour exactly as described under Operation; the reload register may be optimised away.

## Test plan
- Reset then idle: assert reset for 2 cycles, then release → out=0, load_ready=1, busy=0, done=0, tc=0 held for 10 cycles with load_valid=0.
- One-shot: load 5 with enable=1 → out 5,4,3,2,1,0 on consecutive cycles. tc=1 only in the out=0 cycle; then done=1 and load_ready=1.
- Pause and zero load: load 3, then toggle enable 1,0,0,1,1 → out 3,2,2,2,1,0 and tc=1 once. Separately, load 0 → DONE with out=0 and a single tc pulse one cycle after acceptance.
- Ignored load and reset mid-count: load 200, then assert load_valid with 7 while counting → ignored, count continues from 199. Assert reset when out=150 → next cycle out=0, IDLE, load_ready=1.
- Wrap range (WIDTH=8): load 255 with enable high → tc after exactly 255 cycles and no value above 255. With DOWN_COUNTER_AUTO_RELOAD_EN, load 4 → out 4,3,2,1,4,3,… with tc in each cycle out=4 after reload, every 4 cycles and never in DONE.

Source files
------------

// File: rtl/down_counter.sv
// down_counter: loadable down-counter with valid/ready load handshake and a
// one-cycle terminal-count pulse. All outputs are registered.
//
// Optional feature macro: DOWN_COUNTER_AUTO_RELOAD_EN
//   undefined : one-shot; on expiry the count goes to 0 and the FSM enters DONE.
//   defined   : on expiry the count reloads from the last loaded value and the
//               FSM stays in COUNT. A zero load still goes to DONE.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   enable     count permission while counting
//   load_valid load request, held until accepted
//   load_value start value, stable while load_valid is high
//   load_ready block can accept a load (IDLE or DONE)
//   out        current count value
//   busy       high while counting
//   done       high once the count has expired
//   tc         terminal-count pulse, one cycle wide
module down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_tc;
  logic             w_tc_nxt;
  logic             r_busy;
  logic             r_done;
  logic             r_load_ready;
  logic             w_load_acc;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
`endif

  // The registered load_ready mirrors "state is not COUNT".
  assign w_load_acc = load_valid && r_load_ready;

  // Next-state, next-count and terminal-count decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_tc_nxt     = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    w_reload_nxt = r_reload;
`endif
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_load_acc) begin
          w_count_nxt  = load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          w_reload_nxt = load_value;
`endif
          // A zero load expires immediately: tc pulses in the first DONE cycle.
          if (load_value == '0) begin
            w_state_nxt = S_DONE;
            w_tc_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (enable) begin
          // Expire at 1 so the count never underflows past 0.
          if (r_count == WIDTH'(1)) begin
            w_tc_nxt    = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            w_count_nxt = r_reload;
`else
            w_count_nxt = '0;
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // State, datapath and registered output flags; status flags follow next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_tc         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload     <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_tc         <= w_tc_nxt;
      r_busy       <= (w_state_nxt == S_COUNT);
      r_done       <= (w_state_nxt == S_DONE);
      r_load_ready <= (w_state_nxt != S_COUNT);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload     <= w_reload_nxt;
`endif
    end
  end

  assign out        = r_count;
  assign tc         = r_tc;
  assign busy       = r_busy;
  assign done       = r_done;
  assign load_ready = r_load_ready;

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed stimulus for down_counter with a behavioural model
// checked every cycle, plus hand-computed literal expectations.
// Honours DOWN_COUNTER_AUTO_RELOAD_EN in the same way as the design.
module tb_down_counter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             load_ready;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             tc;

  int n_checks = 0;
  int n_fail   = 0;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining count plus counting/expired flags.
  int m_val     = 0;
  int m_reload  = 0;
  bit m_counting = 1'b0;
  bit m_done    = 1'b0;
  bit m_tc      = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_val      = 0;
      m_reload   = 0;
      m_counting = 1'b0;
      m_done     = 1'b0;
      m_tc       = 1'b0;
    end else begin
      m_tc = 1'b0;
      if (!m_counting && load_valid) begin
        m_val    = int'(load_value);
        m_reload = int'(load_value);
        if (m_val == 0) begin
          m_done = 1'b1;
          m_tc   = 1'b1;
        end else begin
          m_counting = 1'b1;
          m_done     = 1'b0;
        end
      end else if (m_counting && enable) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_tc = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          m_val = m_reload;
`else
          m_counting = 1'b0;
          m_done     = 1'b1;
`endif
        end
      end
    end
    #1;
    chk("model_out", 32'(out), 32'(m_val));
    chk("model_busy", 32'(busy), 32'(m_counting));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_tc", 32'(tc), 32'(m_tc));
    chk("model_load_ready", 32'(load_ready), 32'(!m_counting));
  end

  // Drive inputs on the falling edge, then look 2 time units after the rising edge.
  task automatic step(input bit rst, input bit en, input bit lv, input int val);
    @(negedge clk);
    reset      = rst;
    enable     = en;
    load_valid = lv;
    load_value = 8'(val);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    bit pen[4];
    int pexp[4];
    int cyc;
    bit seen;
    pen  = '{1'b1, 1'b0, 1'b0, 1'b1};
    pexp = '{2, 2, 2, 1};

    // Reset for two cycles, then idle for ten.
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      chk("idle_out", 32'(out), 32'd0);
      chk("idle_ready", 32'(load_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_tc", 32'(tc), 32'd0);
    end

    // Zero load from IDLE: straight to DONE with one tc pulse.
    step(1'b0, 1'b1, 1'b1, 0);
    chk("zl_out", 32'(out), 32'd0);
    chk("zl_tc", 32'(tc), 32'd1);
    chk("zl_done", 32'(done), 32'd1);
    step(1'b0, 1'b1, 1'b0, 0);
    chk("zl_tc_drop", 32'(tc), 32'd0);
    chk("zl_done_hold", 32'(done), 32'd1);

    // One-shot load of 5 from DONE.
    step(1'b0, 1'b1, 1'b1, 5);
    chk("os_load_out", 32'(out), 32'd5);
    chk("os_load_busy", 32'(busy), 32'd1);
    chk("os_load_ready", 32'(load_ready), 32'd0);
    for (int k = 4; k >= 1; k--) begin
      step(1'b0, 1'b1, 1'b0, 0);
      chk("os_out", 32'(out), 32'(k));
      chk("os_tc_low", 32'(tc), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 0);
    chk("os_tc", 32'(tc), 32'd1);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    chk("ar_os_out", 32'(out), 32'd5);
    chk("ar_os_done", 32'(done), 32'd0);
    do_reset();
`else
    chk("os_out0", 32'(out), 32'd0);
    chk("os_done", 32'(done), 32'd1);
    chk("os_ready", 32'(load_ready), 32'd1);
`endif

    // Load 3 (back-to-back with the tc cycle in the one-shot build), then pause.
    step(1'b0, 1'b1, 1'b1, 3);
    chk("pz_load_out", 32'(out), 32'd3);
    chk("pz_load_tc", 32'(tc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, pen[i], 1'b0, 0);
      chk("pz_out", 32'(out), 32'(pexp[i]));
      chk("pz_tc_low", 32'(tc), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 0);
    chk("pz_tc", 32'(tc), 32'd1);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    chk("pz_out_end", 32'(out), 32'd3);
`else
    chk("pz_out_end", 32'(out), 32'd0);
`endif
    do_reset();

    // Load ignored while counting; reset mid-count drops a concurrent load.
    step(1'b0, 1'b1, 1'b1, 200);
    chk("ig_load_out", 32'(out), 32'd200);
    step(1'b0, 1'b1, 1'b1, 7);
    chk("ig_out", 32'(out), 32'd199);
    chk("ig_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 49; i++) step(1'b0, 1'b1, 1'b0, 0);
    chk("ig_out150", 32'(out), 32'd150);
    step(1'b1, 1'b1, 1'b1, 9);
    chk("mr_out", 32'(out), 32'd0);
    chk("mr_ready", 32'(load_ready), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_tc", 32'(tc), 32'd0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("mr_dropped", 32'(out), 32'd0);

    // Maximum load: tc after exactly 255 enabled cycles.
    step(1'b0, 1'b1, 1'b1, 255);
    chk("max_load_out", 32'(out), 32'd255);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      if (tc === 1'b1) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    chk("max_tc_cycles", 32'(cyc), 32'd255);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    chk("max_reload_out", 32'(out), 32'd255);

    // Auto-reload of 4: 4,3,2,1,4,... with tc on each reload.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 4);
    chk("ar_load_out", 32'(out), 32'd4);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      chk("ar_out", 32'(out), 32'(((k % 4) == 0) ? 4 : 4 - (k % 4)));
      chk("ar_tc", 32'(tc), 32'((k % 4) == 0));
      chk("ar_done", 32'(done), 32'd0);
    end
`else
    chk("max_out0", 32'(out), 32'd0);
`endif

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
